spi_tx_engine: RTL

SPI master serializer that sits on the read side of the TX FIFO. It pops words from the FIFO, shifts them out MSB-first on MOSI with programmable word size, clock mode and baud rate, and drives one of four active-low chip selects. It captures MISO at the same time and emits each received word with a one-cycle write strobe toward the RX FIFO write port.

---
 rtl/spi_tx_engine.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/spi_tx_engine.sv
// rtl/spi_tx_engine.sv - SPI master serializer draining the TX FIFO and producing RX FIFO writes
module spi_tx_engine #(
  parameter int FIFOWIDTH = 32,
  parameter int DIVWIDTH  = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic                 FifoEmpty,
  input  logic [FIFOWIDTH-1:0] FifoData,
  output logic                 FifoRead,
  input  logic [4:0]           WordSize,
  input  logic                 Cpol,
  input  logic                 Cpha,
  input  logic [DIVWIDTH-1:0]  BaudDiv,
  input  logic [1:0]           CsSelect,
  output logic                 SCLK,
  output logic                 MOSI,
  input  logic                 MISO,
  output logic [3:0]           CS_n,
  output logic [FIFOWIDTH-1:0] RxData,
  output logic                 RxWrite,
  output logic                 Busy
);

  typedef enum logic [2:0] {IDLE, FETCH, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t                 state;
  logic [DIVWIDTH-1:0]    cnt;
  logic [DIVWIDTH-1:0]    h_m1;
  logic [DIVWIDTH-1:0]    h_in;
  logic [5:0]             edge_cnt;
  logic [4:0]             ws;
  logic [4:0]             bit_idx;
  logic [4:0]             next_idx;
  logic                   cpol_l;
  logic                   cpha_l;
  logic [FIFOWIDTH-1:0]   tx;
  logic [FIFOWIDTH-1:0]   rx;
  logic                   odd_edge;
  logic                   last_edge;

  always_comb begin
    h_in      = (BaudDiv == '0) ? '0 : BaudDiv - DIVWIDTH'(1);
    next_idx  = bit_idx - 5'd1;
    // edge_cnt holds edges already issued, so the upcoming edge is odd when it is even
    odd_edge  = ~edge_cnt[0];
    last_edge = (edge_cnt == {ws, 1'b1});
  end

  assign Busy = (state != IDLE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      FifoRead <= 1'b0;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      CS_n     <= 4'hF;
      RxData   <= '0;
      RxWrite  <= 1'b0;
      cnt      <= '0;
      h_m1     <= '0;
      edge_cnt <= '0;
      ws       <= '0;
      bit_idx  <= '0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      tx       <= '0;
      rx       <= '0;
    end else begin
      FifoRead <= 1'b0;
      RxWrite  <= 1'b0;
      case (state)
        IDLE: begin
          SCLK <= Cpol;
          MOSI <= 1'b0;
          CS_n <= 4'hF;
          if (Enable && !FifoEmpty) state <= FETCH;
        end
        FETCH: begin
          tx       <= FifoData;
          rx       <= '0;
          FifoRead <= 1'b1;
          ws       <= WordSize;
          cpol_l   <= Cpol;
          cpha_l   <= Cpha;
          h_m1     <= h_in;
          cnt      <= h_in;
          edge_cnt <= '0;
          bit_idx  <= WordSize;
          CS_n     <= ~(4'b0001 << CsSelect);
          MOSI     <= Cpha ? 1'b0 : FifoData[WordSize];
          state    <= SETUP;
        end
        SETUP, SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - DIVWIDTH'(1);
          end else begin
            cnt      <= h_m1;
            SCLK     <= ~SCLK;
            edge_cnt <= edge_cnt + 6'd1;
            if (odd_edge) begin
              if (cpha_l) begin
                MOSI    <= tx[bit_idx];
                bit_idx <= next_idx;
              end else begin
                rx <= {rx[FIFOWIDTH-2:0], MISO};
              end
            end else begin
              if (cpha_l) begin
                rx <= {rx[FIFOWIDTH-2:0], MISO};
              end else if (!last_edge) begin
                MOSI    <= tx[next_idx];
                bit_idx <= next_idx;
              end
            end
            state <= last_edge ? HOLD : SHIFT;
          end
        end
        HOLD: begin
          SCLK <= cpol_l;
          if (cnt != '0) begin
            cnt <= cnt - DIVWIDTH'(1);
          end else begin
            CS_n    <= 4'hF;
            RxData  <= rx;
            RxWrite <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
